shot_scheduler: RTL and testbench
=================================

SHOT_SCHEDULER -- requirements
Module: shot_scheduler

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 4'd7, the score at which a player wins the game.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port req, input, 2, shot request per player; bit0 is player 0 and bit1 is player 1; level-sensitive.
REQ-005 SHALL have ports p0_xpos/p0_rise/p0_run, input, 5 each, and p0_dir, input, 1: player 0 shot parameters.
REQ-006 SHALL have ports p1_xpos/p1_rise/p1_run, input, 5 each, and p1_dir, input, 1: player 1 shot parameters.
REQ-007 SHALL have port clear_game, input, 1, which starts a new game.
REQ-008 SHALL have port calc_valid, input, 1, the trajectory unit's result-valid pulse.
REQ-009 SHALL have port calc_hit, input, 1, the trajectory unit's hit flag, sampled only with calc_valid.
REQ-010 SHALL have port calc_shoot, output, 1, a one-cycle launch pulse to the trajectory unit.
REQ-011 SHALL have ports calc_xpos/calc_rise/calc_run, output, 5 each, and calc_dir, output, 1: the registered parameters of the granted player.
REQ-012 SHALL have port grant, output, 2, one-hot owner of the trajectory unit; 2'b00 when the unit is unowned.
REQ-013 SHALL have port busy, output, 1, high in ISSUE and WAIT.
REQ-014 SHALL have port done_valid, output, 1, a one-cycle result pulse.
REQ-015 SHALL have ports done_player, output, 1, and done_hit, output, 1, both valid with done_valid.
REQ-016 SHALL have ports score0 and score1, output, 4 each, the per-player hit counts.
REQ-017 SHALL have port game_over, output, 1, and port winner, output, 1.
REQ-018 SHALL have port timeout, output, 1, valid with done_valid.

Function
REQ-019 SHALL implement the states IDLE, ISSUE, WAIT, REPORT and OVER.
REQ-020 IDLE: if req!=0, SHALL choose a player, register that player's parameters into calc_*, set grant one-hot, and go to ISSUE next cycle.
REQ-021 Arbitration SHALL be round-robin: when both request, the player not granted last wins; after reset player 0 has priority.
REQ-022 ISSUE: SHALL assert calc_shoot for exactly one cycle, then go to WAIT; calc_* SHALL stay stable from ISSUE through REPORT.
REQ-023 WAIT: calc_valid=1 SHALL capture calc_hit and go to REPORT; req SHALL be ignored.
REQ-024 REPORT: SHALL pulse done_valid with done_player and done_hit, add 1 to the hitting player's score if done_hit, record the last grant, and clear grant.
REQ-025 REPORT: if the updated score equals WIN_SCORE, SHALL go to OVER and set winner to that player; otherwise SHALL go to IDLE.
REQ-026 Launch latency SHALL be request seen in IDLE -> calc_shoot exactly 1 cycle later.
REQ-027 Release latency SHALL be calc_valid -> done_valid exactly 1 cycle later.
REQ-028 OVER: game_over=1 and all req ignored; clear_game SHALL zero both scores, game_over and winner, then go to IDLE.
REQ-029 clear_game in any state other than OVER SHALL zero both scores and nothing else; an in-flight shot still completes and reports.
REQ-030 Scores SHALL never wrap; an increment is suppressed at 4'd15.
REQ-031 calc_valid outside WAIT SHALL be ignored.

Reset
REQ-032 On rst_n low, SHALL immediately enter IDLE and drive grant=0, calc_*=0, calc_shoot=0, busy=0, done_*=0, scores=0, game_over=0, winner=0, timeout=0, with player 0 priority.
REQ-033 Reset during WAIT SHALL abandon the shot with no done_valid; a late calc_valid after reset SHALL be ignored.

Configuration
REQ-034 With SHOT_WATCHDOG_EN defined, a 6-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-035 With SHOT_WATCHDOG_EN defined, at count 63 without calc_valid the block SHALL go to REPORT with done_hit=0 and timeout=1.
REQ-036 With SHOT_WATCHDOG_EN defined, if calc_valid arrives on the count-63 cycle, the valid result SHALL win.
REQ-037 Without SHOT_WATCHDOG_EN, WAIT SHALL persist until calc_valid, and timeout SHALL be constant 0.

Verification
REQ-038 req=01 with p0=(x4,r2,u3,d1) -> grant=01 next cycle; calc_shoot pulses with calc_xpos=4, rise=2, run=3, dir=1.
REQ-039 req=11 held across three shots -> grants 01, 10, 01.
REQ-040 calc_valid=1 with calc_hit=1 for player 1 -> done_valid, done_player=1, done_hit=1 one cycle later; score1 increments by 1.
REQ-041 Player 0 scores 7 hits -> game_over=1, winner=0, req ignored; clear_game -> scores 0, IDLE.
REQ-042 SHOT_WATCHDOG_EN defined, no calc_valid for 63 WAIT cycles -> done_valid with timeout=1, done_hit=0, score unchanged.
REQ-043 rst_n low mid-WAIT, then calc_valid -> no done_valid; all outputs at reset values.

Source files
------------

// File: rtl/shot_scheduler.sv
// shot_scheduler: round-robin owner of a shared trajectory unit for a two-player shooting game.
// Optional SHOT_WATCHDOG_EN adds a 64-cycle WAIT watchdog that reports a timed-out miss.
module shot_scheduler #(
    parameter logic [3:0] WIN_SCORE = 4'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [4:0] p0_xpos,
    input  logic [4:0] p0_rise,
    input  logic [4:0] p0_run,
    input  logic       p0_dir,
    input  logic [4:0] p1_xpos,
    input  logic [4:0] p1_rise,
    input  logic [4:0] p1_run,
    input  logic       p1_dir,
    input  logic       clear_game,
    input  logic       calc_valid,
    input  logic       calc_hit,
    output logic       calc_shoot,
    output logic [4:0] calc_xpos,
    output logic [4:0] calc_rise,
    output logic [4:0] calc_run,
    output logic       calc_dir,
    output logic [1:0] grant,
    output logic       busy,
    output logic       done_valid,
    output logic       done_player,
    output logic       done_hit,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic       game_over,
    output logic       winner,
    output logic       timeout
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, REPORT, OVER} state_t;

    state_t     state, state_nxt;
    logic       last_pl, pick_pl, cur_pl, hit_q, won, wd_expire;
    logic [3:0] cur_score, inc_score;

    // When both players request, the one not served last goes next.
    assign pick_pl   = (req == 2'b11) ? ~last_pl : req[1];
    assign cur_pl    = grant[1];
    assign cur_score = cur_pl ? score1 : score0;
    assign inc_score = (cur_score == 4'd15) ? 4'd15 : cur_score + 4'd1;
    assign won       = hit_q && !clear_game && (inc_score == WIN_SCORE);

`ifdef SHOT_WATCHDOG_EN
    logic [5:0] wd_cnt;
    logic       to_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              wd_cnt <= '0;
        else if (state == ISSUE) wd_cnt <= '0;
        else if (state == WAIT)  wd_cnt <= wd_cnt + 6'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          to_q <= 1'b0;
        else if (state == WAIT && (calc_valid || wd_expire)) to_q <= !calc_valid;
    end

    assign wd_expire = (state == WAIT) && (wd_cnt == 6'd63);
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req != 2'b00) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (calc_valid || wd_expire) state_nxt = REPORT;
            REPORT:  state_nxt = won ? OVER : IDLE;
            OVER:    if (clear_game) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        calc_shoot  = (state == ISSUE);
        busy        = (state == ISSUE) || (state == WAIT);
        done_valid  = (state == REPORT);
        done_player = (state == REPORT) && cur_pl;
        done_hit    = (state == REPORT) && hit_q;
        game_over   = (state == OVER);
`ifdef SHOT_WATCHDOG_EN
        timeout     = (state == REPORT) && to_q;
`else
        timeout     = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= 2'b00;
            calc_xpos <= '0;
            calc_rise <= '0;
            calc_run  <= '0;
            calc_dir  <= 1'b0;
            last_pl   <= 1'b1;
            hit_q     <= 1'b0;
        end else begin
            if (state == IDLE && req != 2'b00) begin
                grant     <= pick_pl ? 2'b10 : 2'b01;
                calc_xpos <= pick_pl ? p1_xpos : p0_xpos;
                calc_rise <= pick_pl ? p1_rise : p0_rise;
                calc_run  <= pick_pl ? p1_run  : p0_run;
                calc_dir  <= pick_pl ? p1_dir  : p0_dir;
            end
            if (state == WAIT && (calc_valid || wd_expire))
                hit_q <= calc_valid && calc_hit;
            if (state == REPORT) begin
                last_pl <= cur_pl;
                grant   <= 2'b00;
            end
        end
    end

    // clear_game always zeroes the scores; only in OVER does it also drop the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score0 <= '0;
            score1 <= '0;
            winner <= 1'b0;
        end else begin
            if (clear_game) begin
                score0 <= '0;
                score1 <= '0;
            end else if (state == REPORT && hit_q) begin
                if (cur_pl) score1 <= inc_score;
                else        score0 <= inc_score;
            end
            if (state == OVER && clear_game) winner <= 1'b0;
            else if (state == REPORT && won) winner <= cur_pl;
        end
    end
endmodule

// File: tb/tb_shot_scheduler.sv
// Self-checking bench for shot_scheduler: transaction-level model plus directed literal checks.
module tb_shot_scheduler;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [4:0] p0_xpos = '0, p0_rise = '0, p0_run = '0, p1_xpos = '0, p1_rise = '0, p1_run = '0;
    logic       p0_dir = 1'b0, p1_dir = 1'b0, clear_game = 1'b0, calc_valid = 1'b0, calc_hit = 1'b0;
    logic       calc_shoot, calc_dir, busy, done_valid, done_player, done_hit, game_over, winner, timeout;
    logic [4:0] calc_xpos, calc_rise, calc_run;
    logic [1:0] grant;
    logic [3:0] score0, score1;

    int errors = 0, checks = 0;
    localparam int WIN = 7;

    always #5 clk = ~clk;

    shot_scheduler dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .p0_xpos(p0_xpos), .p0_rise(p0_rise), .p0_run(p0_run), .p0_dir(p0_dir),
        .p1_xpos(p1_xpos), .p1_rise(p1_rise), .p1_run(p1_run), .p1_dir(p1_dir),
        .clear_game(clear_game), .calc_valid(calc_valid), .calc_hit(calc_hit),
        .calc_shoot(calc_shoot), .calc_xpos(calc_xpos), .calc_rise(calc_rise),
        .calc_run(calc_run), .calc_dir(calc_dir), .grant(grant), .busy(busy),
        .done_valid(done_valid), .done_player(done_player), .done_hit(done_hit),
        .score0(score0), .score1(score1), .game_over(game_over), .winner(winner),
        .timeout(timeout)
    );

    // Model: the shot phase the spec describes, who owns the unit, and the game tallies.
    int         m_ph;   // 0 idle, 1 issue, 2 wait, 3 report, 4 over
    int         m_wd;
    bit         m_pl, m_last, m_hit, m_to, m_win;
    logic [4:0] m_x, m_r, m_u;
    bit         m_d;
    int         m_sc[2];

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_wd = 0; m_pl = 0; m_last = 1; m_hit = 0; m_to = 0; m_win = 0;
        m_x = '0; m_r = '0; m_u = '0; m_d = 0; m_sc[0] = 0; m_sc[1] = 0;
    endtask

    task automatic model_step();
        int ns;
        if (!rst_n) begin model_reset(); return; end
        case (m_ph)
            0: if (req != 2'b00) begin
                m_pl = (req == 2'b11) ? !m_last : req[1];
                if (m_pl) begin m_x = p1_xpos; m_r = p1_rise; m_u = p1_run; m_d = p1_dir; end
                else      begin m_x = p0_xpos; m_r = p0_rise; m_u = p0_run; m_d = p0_dir; end
                m_ph = 1;
            end
            1: begin m_ph = 2; m_wd = 0; end
            2: begin
                if (calc_valid) begin m_hit = calc_hit; m_to = 0; m_ph = 3; end
`ifdef SHOT_WATCHDOG_EN
                else if (m_wd == 63) begin m_hit = 0; m_to = 1; m_ph = 3; end
`endif
                else m_wd++;
            end
            3: begin
                m_last = m_pl;
                m_ph = 0;
                if (!clear_game && m_hit) begin
                    ns = (m_sc[m_pl] == 15) ? 15 : m_sc[m_pl] + 1;
                    m_sc[m_pl] = ns;
                    if (ns == WIN) begin m_win = m_pl; m_ph = 4; end
                end
            end
            4: if (clear_game) begin m_win = 0; m_ph = 0; end
            default: m_ph = 0;
        endcase
        if (clear_game) begin m_sc[0] = 0; m_sc[1] = 0; end
    endtask

    task automatic compare_all();
        chk("calc_shoot", calc_shoot, m_ph == 1);
        chk("busy", busy, m_ph == 1 || m_ph == 2);
        chk("grant", grant, (m_ph >= 1 && m_ph <= 3) ? (m_pl ? 8'd2 : 8'd1) : 8'd0);
        chk("calc_xpos", calc_xpos, m_x);
        chk("calc_rise", calc_rise, m_r);
        chk("calc_run", calc_run, m_u);
        chk("calc_dir", calc_dir, m_d);
        chk("done_valid", done_valid, m_ph == 3);
        chk("done_player", done_player, m_ph == 3 && m_pl);
        chk("done_hit", done_hit, m_ph == 3 && m_hit);
        chk("timeout", timeout, m_ph == 3 && m_to);
        chk("score0", score0, m_sc[0]);
        chk("score1", score1, m_sc[1]);
        chk("game_over", game_over, m_ph == 4);
        chk("winner", winner, m_win);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full shot from IDLE; returns the grant seen in ISSUE.
    task automatic shot(input logic [1:0] r, input bit hit, output logic [1:0] g);
        req = r;
        cycle();
        g = grant;
        cycle();
        cycle();
        calc_valid = 1'b1; calc_hit = hit;
        cycle();
        chk("shot_done_valid", done_valid, 1);
        calc_valid = 1'b0; calc_hit = 1'b0;
        cycle();
    endtask

    initial begin
        logic [1:0] g;
        model_reset();
        #3 compare_all();
        chk("rst_grant", grant, 0);
        chk("rst_score0", score0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Launch of player 0 with fixed parameters
        p0_xpos = 5'd4; p0_rise = 5'd2; p0_run = 5'd3; p0_dir = 1'b1;
        p1_xpos = 5'd9; p1_rise = 5'd8; p1_run = 5'd7; p1_dir = 1'b0;
        req = 2'b01;
        cycle();
        chk("lit_grant", grant, 2'b01);
        chk("lit_shoot", calc_shoot, 1);
        chk("lit_xpos", calc_xpos, 4);
        chk("lit_rise", calc_rise, 2);
        chk("lit_run", calc_run, 3);
        chk("lit_dir", calc_dir, 1);
        req = 2'b00;
        cycle();
        chk("lit_shoot_once", calc_shoot, 0);
        calc_valid = 1'b1; calc_hit = 1'b0;
        cycle();
        chk("lit_done_valid", done_valid, 1);
        calc_valid = 1'b0;
        cycle();

        // Round-robin with both requesting, then a player-1 hit
        do_reset();
        shot(2'b11, 0, g); chk("rr0", g, 2'b01);
        shot(2'b11, 0, g); chk("rr1", g, 2'b10);
        shot(2'b11, 0, g); chk("rr2", g, 2'b01);
        req = 2'b10;
        cycle(); cycle();
        calc_valid = 1'b1; calc_hit = 1'b1;
        cycle();
        chk("p1_done_player", done_player, 1);
        chk("p1_done_hit", done_hit, 1);
        calc_valid = 1'b0; req = 2'b00;
        cycle();
        chk("p1_score", score1, 1);

        // Player 0 wins, requests ignored in OVER, clear restarts
        do_reset();
        for (int i = 0; i < WIN; i++) shot(2'b01, 1, g);
        chk("win_over", game_over, 1);
        chk("win_winner", winner, 0);
        chk("win_score0", score0, 7);
        req = 2'b11;
        cycle(); cycle();
        chk("over_grant", grant, 0);
        chk("over_busy", busy, 0);
        req = 2'b00; clear_game = 1'b1;
        cycle();
        clear_game = 1'b0;
        chk("clr_score0", score0, 0);
        chk("clr_over", game_over, 0);
        shot(2'b01, 0, g); chk("clr_regrant", g, 2'b01);

        // Reset mid-WAIT abandons the shot; late calc_valid is ignored
        req = 2'b01;
        cycle();
        req = 2'b00;
        cycle(); cycle();
        rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        chk("rst_wait_busy", busy, 0);
        calc_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("rst_wait_done", done_valid, 0);
        calc_valid = 1'b0;
        cycle();

`ifdef SHOT_WATCHDOG_EN
        begin
            int n = 0;
            req = 2'b01;
            cycle();
            req = 2'b00;
            while (!done_valid && n < 100) begin cycle(); n++; end
            chk("wd_fired", done_valid, 1);
            chk("wd_timeout", timeout, 1);
            chk("wd_hit", done_hit, 0);
            chk("wd_latency", n, 65);
            cycle();
            chk("wd_score", score0, 0);
        end
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            req        = 2'($urandom_range(0, 3));
            p0_xpos    = 5'($urandom); p0_rise = 5'($urandom); p0_run = 5'($urandom); p0_dir = 1'($urandom);
            p1_xpos    = 5'($urandom); p1_rise = 5'($urandom); p1_run = 5'($urandom); p1_dir = 1'($urandom);
            calc_valid = ($urandom_range(0, 3) == 0);
            calc_hit   = ($urandom_range(0, 2) != 0);
            clear_game = (m_ph == 4) ? ($urandom_range(0, 7) == 0)
                       : (m_ph != 3 && $urandom_range(0, 150) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
